// File: rtl/branch_resolve.sv
// EX-stage branch resolution: computes the real outcome and target of
// BRANCH/JAL/JALR, compares them with the fetch prediction, issues a
// registered redirect on mispredict, and holds o_flush for a fixed number
// of cycles while the wrong-path IF/ID instructions drain. Two performance
// counters track resolved transfers and mispredicts.
module branch_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_stall,
    input  logic             i_is_br,
    input  logic             i_is_jal,
    input  logic             i_is_jalr,
    input  logic [2:0]       i_funct3,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_imm,
    input  logic [31:0]      i_rs1_data,
    input  logic             i_pred_taken,
    input  logic [31:0]      i_pred_target,
    input  logic             i_br_eq,
    input  logic             i_br_lt,
    output logic             o_br_un,
    output logic             o_redirect,
    output logic [31:0]      o_redirect_pc,
    output logic             o_flush,
    output logic             o_taken,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Counter is preloaded with FLUSH_CYCLES-1 so the FLUSH state lasts
    // exactly FLUSH_CYCLES cycles, including the one where it reaches zero.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         flush_cnt_q, flush_cnt_d;
    logic               redirect_q, redirect_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               taken_q, taken_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

    logic               resolve;
    logic               is_illegal;
    logic               cond;
    logic               taken;
    logic [31:0]        target;
    logic [31:0]        fall_through;
    logic               mispredict;

    // Comparator signedness follows funct3 bit 1 (BLTU/BGEU).
    assign o_br_un = i_funct3[1];

    // Outcome, target and mispredict evaluation for the current EX instruction.
    always_comb begin
        resolve    = i_valid & ~i_stall & (i_is_br | i_is_jal | i_is_jalr)
                     & (state_q == IDLE);
        is_illegal = i_is_br & (i_funct3[2:1] == 2'b01);

        cond = 1'b0;
        case (i_funct3)
            3'b000:          cond = i_br_eq;
            3'b001:          cond = ~i_br_eq;
            3'b100, 3'b110:  cond = i_br_lt;
            3'b101, 3'b111:  cond = ~i_br_lt;
            default:         cond = 1'b0;
        endcase

        taken        = i_is_jal | i_is_jalr | (i_is_br & cond);
        fall_through = i_pc + 32'd4;
        if (i_is_jalr) begin
            target = (i_rs1_data + i_imm) & ~32'h1;
        end else begin
            target = i_pc + i_imm;
        end

        mispredict = (taken != i_pred_taken)
                   | (taken & (target != i_pred_target));
    end

    // Next-state, flush countdown and registered-output updates.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_d    = 1'b0;
        illegal_d     = 1'b0;
        redirect_pc_d = redirect_pc_q;
        taken_d       = taken_q;
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        case (state_q)
            IDLE: begin
                if (resolve) begin
                    taken_d   = taken;
                    illegal_d = is_illegal;
                    br_cnt_d  = br_cnt_q + 1'b1;
                    if (mispredict) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = taken ? target : fall_through;
                        mispred_cnt_d = mispred_cnt_q + 1'b1;
                        state_d       = FLUSH;
                        flush_cnt_d   = FLUSH_LOAD;
                    end
                end
            end
            FLUSH: begin
                // Wrong-path inputs are ignored; stall does not extend the flush.
                if (flush_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                flush_cnt_d = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            flush_cnt_q   <= 4'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            taken_q       <= 1'b0;
            illegal_q     <= 1'b0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            taken_q       <= taken_d;
            illegal_q     <= illegal_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_redirect    = redirect_q;
    assign o_redirect_pc = redirect_pc_q;
    assign o_flush       = (state_q == FLUSH);
    assign o_taken       = taken_q;
    assign o_illegal     = illegal_q;
    assign o_br_cnt      = br_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;

endmodule
